npc_predict_unit: RTL and testbench

Sequential successor to the combinational next-PC logic, used in the pipelined datapath's fetch stage.
- Owns the PC register.
- Predicts the next PC through a parametrised direct-mapped branch target buffer (BTB) with saturating counters.
- Accepts branch/jump resolution from EX, updates the BTB, and redirects fetch on mispredict.
- No delay slot: the fall-through PC is resolved PC + 4.

---
 rtl/npc_pkg.sv | 46 ++++
 rtl/npc_btb.sv | 65 ++++++
 rtl/npc_predict_unit.sv | 83 ++++++++
 tb/tb_npc_predict_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and helpers for the fetch-stage next-PC predictor and its BTB.
// Counters are held in a fixed-width field; only the low CNT_BITS are ever non-zero.
package npc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          CNT_MAX      = 8;
  localparam int          TAG_MAX      = 30;

  typedef logic [CNT_MAX-1:0] cnt_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    cnt_t               counter;
  } btb_entry_t;

  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_bits(input int entries);
    return 30 - $clog2(entries);
  endfunction

  function automatic cnt_t cnt_weak_taken(input int bits);
    return cnt_t'(1) << (bits - 1);
  endfunction

  function automatic cnt_t cnt_weak_not_taken(input int bits);
    return (cnt_t'(1) << (bits - 1)) - cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_max(input int bits);
    return (cnt_t'(1) << bits) - cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_inc(input cnt_t c, input int bits);
    return (c == cnt_max(bits)) ? c : c + cnt_t'(1);
  endfunction

  function automatic cnt_t cnt_dec(input cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/npc_btb.sv
// Direct-mapped BTB: combinational lookup on the fetch PC, registered update from EX.
// Lookups read the array before any same-cycle update lands, so updates show from the next cycle.
module npc_btb
  import npc_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lk_word_i,
  output logic        lk_taken_o,
  output logic [31:0] lk_target_o,
  input  logic        upd_vld_i,
  input  logic [29:0] upd_word_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int IW = idx_bits(ENTRIES);
  localparam int TW = tag_bits(ENTRIES);

  btb_entry_t entry_q [ENTRIES];

  logic [IW-1:0] lk_idx;
  logic [IW-1:0] upd_idx;
  logic [TW-1:0] lk_tag;
  logic [TW-1:0] upd_tag;
  logic          lk_hit;
  logic          upd_hit;

  assign lk_idx  = lk_word_i[IW-1:0];
  assign lk_tag  = lk_word_i[29:IW];
  assign upd_idx = upd_word_i[IW-1:0];
  assign upd_tag = upd_word_i[29:IW];

  assign lk_hit  = entry_q[lk_idx].valid && (entry_q[lk_idx].tag == TAG_MAX'(lk_tag));
  assign upd_hit = entry_q[upd_idx].valid && (entry_q[upd_idx].tag == TAG_MAX'(upd_tag));

  assign lk_taken_o  = lk_hit && entry_q[lk_idx].counter[CNT_BITS-1];
  assign lk_target_o = entry_q[lk_idx].target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                        counter: cnt_weak_not_taken(CNT_BITS)};
      end
    end else if (upd_vld_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          entry_q[upd_idx].counter <= cnt_inc(entry_q[upd_idx].counter, CNT_BITS);
          entry_q[upd_idx].target  <= upd_target_i;
        end else begin
          entry_q[upd_idx].counter <= cnt_dec(entry_q[upd_idx].counter);
        end
      end else if (upd_taken_i) begin
        // a taken miss steals the slot regardless of who held it
        entry_q[upd_idx] <= '{valid: 1'b1, tag: TAG_MAX'(upd_tag), target: upd_target_i,
                              counter: cnt_weak_taken(CNT_BITS)};
      end
    end
  end

endmodule

// File: rtl/npc_predict_unit.sv
// Fetch PC register with BTB-driven next-PC prediction and EX mispredict redirect.
// Next PC lands one edge later; redirect beats stall, stall holds PC, BTB updates ignore stall.
module npc_predict_unit
  import npc_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter int          CNT_BITS    = 2,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_mispredict,
  output logic        redirect,
  output logic [31:0] mispred_cnt
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;
  logic        btb_taken;
  logic [31:0] btb_target;
  logic [31:0] res_next;

  npc_btb #(
    .ENTRIES  (BTB_ENTRIES),
    .CNT_BITS (CNT_BITS)
  ) u_btb (
    .clk          (clk),
    .rst          (reset),
    .lk_word_i    (pc_q[31:2]),
    .lk_taken_o   (btb_taken),
    .lk_target_o  (btb_target),
    .upd_vld_i    (res_valid),
    .upd_word_i   (res_pc[31:2]),
    .upd_taken_i  (res_taken),
    .upd_target_i (res_target)
  );

  assign PC          = pc_q;
  assign PC4         = pc_q + 32'd4;
  assign pred_taken  = btb_taken;
  assign pred_target = btb_taken ? btb_target : PC4;
  assign redirect    = res_valid & res_mispredict;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    res_next = res_taken ? res_target : res_pc + 32'd4;
    pc_d     = pc_q;
    if (redirect) begin
      pc_d = res_next;
    end else if (!stall) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (redirect && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from a table-based model, a negedge monitor compares.
module tb_npc_predict_unit;

  localparam int          N      = 16;
  localparam int          CB     = 2;
  localparam int          IW     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_mispredict;
  logic        redirect;
  logic [31:0] mispred_cnt;

  npc_predict_unit #(
    .BTB_ENTRIES (N),
    .CNT_BITS    (CB),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .PC             (PC),
    .PC4            (PC4),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .res_mispredict (res_mispredict),
    .redirect       (redirect),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pt;
    logic [31:0] ptgt;
    logic        rd;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Reference model: plain tables indexed by slot, counters as integers
  logic [31:0] m_pc;
  logic [31:0] m_mc;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_cnt [N];

  function automatic void m_reset();
    m_pc = RST_PC;
    m_mc = 32'd0;
    for (int i = 0; i < N; i++) begin
      m_v[i]   = 1'b0;
      m_tag[i] = 32'd0;
      m_tgt[i] = 32'd0;
      m_cnt[i] = (1 << (CB - 1)) - 1;
    end
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int idx;
    idx = int'((pc >> 2) & (N - 1));
    t   = m_v[idx] && (m_tag[idx] == (pc >> (2 + IW))) && (m_cnt[idx] >= (1 << (CB - 1)));
    tgt = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got no expectation expected one at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("PC", PC, e.pc);
        chk("PC4", PC4, e.pc4);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
        chk("pred_target", pred_target, e.ptgt);
        chk("redirect", {31'd0, redirect}, {31'd0, e.rd});
        chk("mispred_cnt", mispred_cnt, e.mc);
      end
    end
  end

  // One cycle: drive inputs, push the expected view of this cycle, then advance the model past the edge
  task automatic step(input bit rst_i, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit rt, input logic [31:0] rtg, input bit rm);
    exp_t        e;
    bit          t;
    logic [31:0] tgt;
    logic [31:0] nxt;
    int          idx;
    int          cmax;
    reset = rst_i; stall = st; res_valid = rv; res_pc = rpc;
    res_taken = rt; res_target = rtg; res_mispredict = rm;
    if (rst_i) m_reset();
    m_predict(m_pc, t, tgt);
    e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.pt = t; e.ptgt = tgt; e.rd = rv && rm; e.mc = m_mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rst_i) begin
      m_reset();
    end else begin
      if (rv && rm) nxt = rt ? rtg : rpc + 32'd4;
      else if (st)  nxt = m_pc;
      else          nxt = tgt;
      if (rv && rm && (m_mc != 32'hFFFF_FFFF)) m_mc = m_mc + 32'd1;
      if (rv) begin
        cmax = (1 << CB) - 1;
        idx  = int'((rpc >> 2) & (N - 1));
        if (m_v[idx] && (m_tag[idx] == (rpc >> (2 + IW)))) begin
          if (rt) begin
            m_cnt[idx] = (m_cnt[idx] < cmax) ? m_cnt[idx] + 1 : cmax;
            m_tgt[idx] = rtg;
          end else begin
            m_cnt[idx] = (m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0;
          end
        end else if (rt) begin
          m_v[idx]   = 1'b1;
          m_tag[idx] = rpc >> (2 + IW);
          m_tgt[idx] = rtg;
          m_cnt[idx] = 1 << (CB - 1);
        end
      end
      m_pc = nxt;
    end
  endtask

  task automatic idle(input int n, input bit st);
    repeat (n) step(1'b0, st, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] rpc, input bit rt, input logic [31:0] rtg, input bit rm);
    step(1'b0, 1'b0, 1'b1, rpc, rt, rtg, rm);
  endtask

  // Not-taken mispredict at addr-4 lands fetch on addr
  task automatic redir(input logic [31:0] addr);
    resolve(addr - 32'd4, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; res_valid = 1'b0; res_pc = '0;
    res_taken = 1'b0; res_target = '0; res_mispredict = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(3, 1'b0);

    resolve(32'h3010, 1'b1, 32'h3040, 1'b1);
    idle(2, 1'b0);
    redir(32'h3010);
    idle(1, 1'b0);

    resolve(32'h3010, 1'b0, 32'd0, 1'b1);
    resolve(32'h3010, 1'b0, 32'd0, 1'b0);
    redir(32'h3010);
    idle(1, 1'b0);
    repeat (3) resolve(32'h3010, 1'b1, 32'h3040, 1'b1);
    redir(32'h3010);
    idle(1, 1'b0);

    step(1'b0, 1'b1, 1'b1, 32'h30FC, 1'b0, 32'd0, 1'b1);
    idle(3, 1'b1);
    idle(2, 1'b0);

    resolve(32'h3050, 1'b1, 32'h3080, 1'b1);
    redir(32'h3010);
    idle(1, 1'b0);
    redir(32'h3050);
    idle(1, 1'b0);

    redir(32'h3050);
    resolve(32'h3010, 1'b1, 32'h3040, 1'b0);
    redir(32'h3050);
    idle(1, 1'b0);

    redir(32'hFFFF_FFFC);
    idle(2, 1'b0);

    step(1'b1, 1'b0, 1'b1, 32'h3020, 1'b1, 32'h3500, 1'b1);
    idle(2, 1'b0);
    redir(32'h3010);
    idle(1, 1'b0);

    for (int i = 0; i < 600; i++) begin
      bit          r_rst;
      bit          r_st;
      bit          r_rv;
      bit          r_rt;
      bit          r_rm;
      logic [31:0] r_pc;
      logic [31:0] r_tg;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_rv  = ($urandom_range(0, 2) == 0);
      r_rt  = $urandom_range(0, 1) == 1;
      r_rm  = $urandom_range(0, 1) == 1;
      r_pc  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'h3000 + 32'(4 * $urandom_range(0, 47));
      r_tg  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'h3000 + 32'(4 * $urandom_range(0, 47));
      step(r_rst, r_st, r_rv, r_pc, r_rt, r_tg, r_rm);
    end
    idle(2, 1'b0);

    mon_en = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
